logic_fold_unit: RTL and testbench
==================================

// Module: logic_fold_unit
// PURPOSE
//   Streaming, parametrised successor to the single-bit AND gate. Accepts a packet of WIDTH-bit words over a
//   valid/ready handshake and folds them bitwise with a selected logic op (AND/OR/XOR, inverted forms, ANDN, PASS).
//   It returns one registered result per packet, with zero/all-ones flags and a word count.
//   Sits beside the ALU as a multi-cycle logic/reduction engine fed by the datapath sequencer.
// PARAMETERS
//   WIDTH   32  data word width in bits (>=1)
//   CNT_W   8   word-counter width; count saturates at 2^CNT_W-1
// PORTS
//   Clk         in   1       system clock; all state updates on rising edge
//   Reset       in   1       synchronous, active-high reset
//   in_valid    in   1       input word valid
//   in_ready    out  1       unit can accept a word this cycle
//   in_data     in   WIDTH   input word
//   in_first    in   1       word starts a packet; samples in_op
//   in_last     in   1       word ends a packet
//   in_op       in   3       000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 ANDN (acc&~w), 111 PASS
//   out_valid   out  1       result valid; held until out_ready
//   out_ready   in   1       consumer accepts result
//   out_data    out  WIDTH   folded result
//   out_zero    out  1       out_data == 0
//   out_ones    out  1       out_data == all ones
//   out_count   out  CNT_W   words in packet (saturating)
//   drop_pulse  out  1       1-cycle pulse: a word was discarded (non-first word while IDLE)
//   abort_pulse out  1       1-cycle pulse: open packet restarted by a new in_first
// BEHAVIOUR
//   Accept = in_valid & in_ready. in_ready = (state != OUT). Combinational only from state.
//   States: IDLE -> ACCUM on accepted first&~last; IDLE -> OUT on accepted first&last;
//     ACCUM -> OUT on accepted last; OUT -> IDLE on out_valid&out_ready.
//   First word: acc <= in_data; op_r <= in_op; count <= 1. in_op is ignored on non-first words.
//   Fold of each later word w: AND/NAND: acc&w; OR/NOR: acc|w; XOR/XNOR: acc^w; ANDN: acc&~w; PASS: w.
//     Count increments, saturating at all ones.
//   Result: NAND/NOR/XNOR invert the final acc; other ops output acc unchanged.
//     A single-word packet yields in_data, or ~in_data for the inverted ops.
//   Latency: last word accepted at cycle t -> out_valid=1 at t+1. Outputs stay stable until handshake.
//   in_ready=0 in OUT, so no packet overlaps an unconsumed result. Back-to-back throughput: 1 result per N+1 cycles.
//   out_zero/out_ones/out_count are registered with out_data and are valid only while out_valid=1.
//   Boundaries:
//     - Accepted word without in_first in IDLE: consumed, discarded, drop_pulse=1 the next cycle, state unchanged.
//     - Accepted in_first in ACCUM: current packet discarded, new packet begins with this word,
//       abort_pulse=1 the next cycle.
//     - in_first & in_last in ACCUM: abort, then immediate OUT holding the single-word result.
//     - in_valid=0: no state change. out_ready while out_valid=0: ignored.
//     - Reset mid-packet or in OUT: packet and result discarded; no output pulse.
//   Reset values: state=IDLE, out_valid=0, out_data=0, out_zero=0, out_ones=0, out_count=0,
//     drop_pulse=0, abort_pulse=0, in_ready=1 from the first cycle after reset.
// TESTING
//   1 AND packet 0xFF00FF00, 0x0FF00FF0, 0xFFFFFFFF (first/—/last) -> out_data=0x0F000F00, count=3, zero=0, ones=0,
//     out_valid one cycle after the last word.
//   2 XNOR single word 0xFFFFFFFF (first&last) -> out_data=0, out_zero=1, count=1; hold out_ready=0 for 5 cycles
//     -> out_valid stays 1, data stable, in_ready=0.
//   3 OR packet 0x1, 0x2, then in_first with NOR op and 0x0, then last 0x0 -> abort_pulse once,
//     out_data=0xFFFFFFFF, ones=1, count=2.
//   4 IDLE, word 0x1234 without first -> drop_pulse once, no out_valid; then ANDN 0xF0F0, 0x00F0 -> out_data=0xF000.
//   5 CNT_W=2 AND packet of 6 words of 0xFFFFFFFF -> count=3 (saturated), out_data=0xFFFFFFFF.
//   6 Reset asserted in ACCUM and again in OUT -> next cycle out_valid=0, in_ready=1;
//     a following XOR packet 0xA, 0x5 -> 0xF.

Source files
------------

// File: rtl/logic_fold_unit.sv
// logic_fold_unit: streaming bitwise fold of a word packet with a selectable logic op
module logic_fold_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] out_count,
  output logic             drop_pulse,
  output logic             abort_pulse
);
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
  state_t state;
  logic [WIDTH-1:0] acc, fold, next_acc, res;
  logic [2:0] op_r, next_op;
  logic [CNT_W-1:0] cnt, next_cnt;
  assign in_ready = state != OUT;
  // fold the incoming word into the accumulator; a first word restarts the packet
  always_comb begin
    fold = (op_r == 3'b000 || op_r == 3'b011) ? acc & in_data :
           (op_r == 3'b001 || op_r == 3'b100) ? acc | in_data :
           (op_r == 3'b010 || op_r == 3'b101) ? acc ^ in_data :
           (op_r == 3'b110) ? acc & ~in_data : in_data;
    next_acc = in_first ? in_data : fold;
    next_op = in_first ? in_op : op_r;
    next_cnt = in_first ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);
    res = (next_op == 3'b011 || next_op == 3'b100 || next_op == 3'b101) ? ~next_acc : next_acc;
  end
  // packet state machine with registered result and event pulses
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      acc <= '0;
      op_r <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_zero <= 1'b0;
      out_ones <= 1'b0;
      out_count <= '0;
      drop_pulse <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      abort_pulse <= 1'b0;
      if (state == OUT) begin
        if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
        end
      end else if (in_valid) begin
        if (in_first || state == ACCUM) begin
          acc <= next_acc;
          op_r <= next_op;
          cnt <= next_cnt;
          abort_pulse <= in_first && state == ACCUM;
          if (in_last) begin
            state <= OUT;
            out_valid <= 1'b1;
            out_data <= res;
            out_zero <= res == '0;
            out_ones <= &res;
            out_count <= next_cnt;
          end else begin
            state <= ACCUM;
          end
        end else begin
          drop_pulse <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_logic_fold_unit.sv
// tb_logic_fold_unit: directed and random packets checked against a reduction model
module tb_logic_fold_unit;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0] in_op = '0;
  logic in_ready, out_valid, out_zero, out_ones, drop_pulse, abort_pulse;
  logic [31:0] out_data;
  logic [7:0] out_count;
  logic s_in_ready, s_out_valid, s_out_zero, s_out_ones, s_drop_pulse, s_abort_pulse;
  logic [31:0] s_out_data;
  logic [1:0] s_out_count;
  int vectors = 0, miscompares = 0;
  logic [31:0] pkt[$];
  logic [2:0] pkt_op;

  always #5 Clk = ~Clk;

  logic_fold_unit #(.WIDTH(32), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first(in_first), .in_last(in_last), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero), .out_ones(out_ones),
    .out_count(out_count), .drop_pulse(drop_pulse), .abort_pulse(abort_pulse));

  logic_fold_unit #(.WIDTH(32), .CNT_W(2)) sdut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_first(in_first), .in_last(in_last), .in_op(in_op), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_data(s_out_data), .out_zero(s_out_zero), .out_ones(s_out_ones),
    .out_count(s_out_count), .drop_pulse(s_drop_pulse), .abort_pulse(s_abort_pulse));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fold_ref(logic [2:0] op);
    logic [31:0] a;
    a = pkt[0];
    for (int i = 1; i < pkt.size(); i++)
      case (op)
        3'd0, 3'd3: a = a & pkt[i];
        3'd1, 3'd4: a = a | pkt[i];
        3'd2, 3'd5: a = a ^ pkt[i];
        3'd6:       a = a & ~pkt[i];
        default:    a = pkt[i];
      endcase
    return (op == 3'd3 || op == 3'd4 || op == 3'd5) ? ~a : a;
  endfunction

  task automatic idle();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic send(logic [31:0] w, logic f, logic l, logic [2:0] op);
    in_valid = 1'b1;
    in_data = w;
    in_first = f;
    in_last = l;
    in_op = op;
    @(posedge Clk);
    @(negedge Clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last = 1'b0;
    in_data = $urandom;
  endtask

  task automatic chk_result(logic [31:0] exp, int n);
    chk("out_valid", out_valid, 1);
    chk("in_ready_out", in_ready, 0);
    chk("out_data", out_data, exp);
    chk("out_zero", out_zero, exp == 0);
    chk("out_ones", out_ones, exp == 32'hFFFF_FFFF);
    chk("out_count", out_count, n > 255 ? 255 : n);
    chk("sat_count", s_out_count, n > 3 ? 3 : n);
    chk("sat_data", s_out_data, exp);
  endtask

  task automatic take();
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    chk("out_valid_clr", out_valid, 0);
    chk("in_ready_idle", in_ready, 1);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    idle();
    Reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_pulses", {drop_pulse, abort_pulse}, 0);
  endtask

  task automatic run_pkt(bit gaps);
    logic [31:0] exp;
    int n;
    n = pkt.size();
    exp = fold_ref(pkt_op);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle();
      send(pkt[i], i == 0, i == n - 1, i == 0 ? pkt_op : 3'($urandom));
      if (i != n - 1) chk("mid_valid", out_valid, 0);
    end
    chk_result(exp, n);
  endtask

  initial begin
    logic [31:0] held;
    idle();
    idle();
    chk("reset_valid", out_valid, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_data", out_data, 0);
    chk("reset_flags", {out_zero, out_ones, drop_pulse, abort_pulse}, 0);
    chk("reset_count", out_count, 0);
    Reset = 1'b0;
    // 1: AND packet
    pkt = '{32'hFF00FF00, 32'h0FF00FF0, 32'hFFFFFFFF};
    pkt_op = 3'd0;
    run_pkt(0);
    chk("t1_const", out_data, 32'h0F000F00);
    take();
    // 2: XNOR single word, held result
    pkt = '{32'hFFFFFFFF};
    pkt_op = 3'd5;
    run_pkt(0);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_first = 1'b1;
      idle();
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_data", out_data, held);
      chk("t2_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    chk("t2_zero", out_zero, 1);
    take();
    // 3: OR packet aborted by a NOR packet
    send(32'h1, 1, 0, 3'd1);
    send(32'h2, 0, 0, 3'd7);
    chk("t3_no_abort", abort_pulse, 0);
    send(32'h0, 1, 0, 3'd4);
    chk("t3_abort", abort_pulse, 1);
    send(32'h0, 0, 1, 3'd0);
    chk("t3_abort_once", abort_pulse, 0);
    chk_result(32'hFFFFFFFF, 2);
    take();
    // 4: stray word in IDLE, then ANDN
    send(32'h1234, 0, 0, 3'd0);
    chk("t4_drop", drop_pulse, 1);
    chk("t4_no_valid", out_valid, 0);
    idle();
    chk("t4_drop_once", drop_pulse, 0);
    send(32'h1234, 0, 1, 3'd0);
    chk("t4_drop_last", drop_pulse, 1);
    chk("t4_no_valid2", out_valid, 0);
    pkt = '{32'hF0F0, 32'h00F0};
    pkt_op = 3'd6;
    run_pkt(0);
    chk("t4_const", out_data, 32'hF000);
    take();
    // 5: count saturation
    pkt = '{};
    for (int i = 0; i < 6; i++) pkt.push_back(32'hFFFFFFFF);
    pkt_op = 3'd0;
    run_pkt(0);
    take();
    // abort with first&last in ACCUM
    send(32'h55, 1, 0, 3'd1);
    send(32'h0F0F0F0F, 1, 1, 3'd3);
    chk("abort_fl_pulse", abort_pulse, 1);
    chk_result(32'hF0F0F0F0, 1);
    take();
    // 6: reset in ACCUM and in OUT
    send(32'h77, 1, 0, 3'd2);
    do_reset();
    send(32'h77, 1, 1, 3'd2);
    chk("t6_out", out_valid, 1);
    do_reset();
    chk("t6_data", out_data, 0);
    pkt = '{32'hA, 32'h5};
    pkt_op = 3'd2;
    run_pkt(0);
    chk("t6_const", out_data, 32'hF);
    take();
    // random packets
    for (int p = 0; p < 40; p++) begin
      pkt = '{};
      for (int i = 0; i < $urandom_range(1, 8); i++)
        pkt.push_back($urandom_range(0, 7) == 0 ? 32'hFFFFFFFF : $urandom);
      pkt_op = 3'($urandom);
      run_pkt(1);
      for (int i = 0; i < $urandom_range(0, 2); i++) begin
        idle();
        chk("rnd_hold", out_valid, 1);
      end
      take();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
